// File: rtl/line_burst_pkg.sv
// Shared types and constants for the 256-bit line to 64-bit burst adapter.
// Honours LINE_BURST_WRAP_EN (critical-beat-first burst addressing).
package line_burst_pkg;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int BEATS      = LINE_W / BURST_W;
  localparam int BEAT_CNT_W = $clog2(BEATS);
  localparam int OFFSET_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wrap bursts keep the beat-select bits so memory starts at the critical word.
`ifdef LINE_BURST_WRAP_EN
  localparam logic [ADDR_W-1:0] BASE_MASK = 32'hFFFF_FFF8;
`else
  localparam logic [ADDR_W-1:0] BASE_MASK = 32'hFFFF_FFE0;
`endif

  function automatic logic [ADDR_W-1:0] burst_base(input logic [ADDR_W-1:0] addr);
    return addr & BASE_MASK;
  endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// Cache line port plus burst memory port seen by the line_burst_adapter.
// slave = adapter view, master = cache/memory environment view.
interface line_burst_adapter_if;
  import line_burst_pkg::*;

  logic [ADDR_W-1:0]  line_address_i;
  logic [LINE_W-1:0]  line_rdata_o;
  logic [LINE_W-1:0]  line_wdata_i;
  logic               line_read_i;
  logic               line_write_i;
  logic               line_resp_o;
  logic [ADDR_W-1:0]  burst_address_o;
  logic [BURST_W-1:0] burst_rdata_i;
  logic [BURST_W-1:0] burst_wdata_o;
  logic               burst_read_o;
  logic               burst_write_o;
  logic               burst_resp_i;

  modport slave (
    input  line_address_i, line_wdata_i, line_read_i, line_write_i,
    input  burst_rdata_i, burst_resp_i,
    output line_rdata_o, line_resp_o,
    output burst_address_o, burst_wdata_o, burst_read_o, burst_write_o
  );

  modport master (
    output line_address_i, line_wdata_i, line_read_i, line_write_i,
    output burst_rdata_i, burst_resp_i,
    input  line_rdata_o, line_resp_o,
    input  burst_address_o, burst_wdata_o, burst_read_o, burst_write_o
  );

endinterface

// File: rtl/line_burst_adapter.sv
// Turns each cache line read/write into one four-beat memory burst.
// LINE_BURST_WRAP_EN selects critical-beat-first wrap ordering.
module line_burst_adapter
  import line_burst_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  line_burst_adapter_if.slave bus
);

  state_t                  state_reg, state_next;
  logic [BEAT_CNT_W-1:0]   cnt_reg;
  logic [BEAT_CNT_W-1:0]   slot;
  logic [ADDR_W-1:0]       addr_reg;
  logic [BURST_W-1:0]      wbeat_reg [BEATS];
  logic [BURST_W-1:0]      rbeat_reg [BEATS];
  logic                    accept;
  logic                    beat;

  assign accept = (state_reg == IDLE) && (bus.line_read_i || bus.line_write_i);
  assign beat   = bus.burst_resp_i && ((state_reg == READ) || (state_reg == WRITE));

`ifdef LINE_BURST_WRAP_EN
  assign slot = addr_reg[OFFSET_W-1:OFFSET_W-BEAT_CNT_W] + cnt_reg;
`else
  assign slot = cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // Read has priority when both requests arrive together.
        if (bus.line_read_i)       state_next = READ;
        else if (bus.line_write_i) state_next = WRITE;
      end
      READ, WRITE: begin
        if (beat && (cnt_reg == BEAT_CNT_W'(BEATS - 1))) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      addr_reg <= '0;
    end else if (accept) begin
      cnt_reg  <= '0;
      addr_reg <= burst_base(bus.line_address_i);
    end else if (beat) begin
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          wbeat_reg[gi] <= '0;
          rbeat_reg[gi] <= '0;
        end else begin
          if (accept && !bus.line_read_i)
            wbeat_reg[gi] <= bus.line_wdata_i[gi*BURST_W +: BURST_W];
          if ((state_reg == READ) && bus.burst_resp_i && (slot == BEAT_CNT_W'(gi)))
            rbeat_reg[gi] <= bus.burst_rdata_i;
        end
      end
      assign bus.line_rdata_o[gi*BURST_W +: BURST_W] = rbeat_reg[gi];
    end
  endgenerate

  assign bus.line_resp_o     = (state_reg == DONE);
  assign bus.burst_read_o    = (state_reg == READ);
  assign bus.burst_write_o   = (state_reg == WRITE);
  assign bus.burst_address_o = addr_reg;
  assign bus.burst_wdata_o   = (state_reg == WRITE) ? wbeat_reg[slot] : '0;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter against a beat/slot reference model.
module tb_line_burst_adapter;
  import line_burst_pkg::*;

  logic clk = 1'b0;
  logic rst;
  line_burst_adapter_if bif();

  line_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: burst start address and the line slot that beat k belongs to.
  function automatic logic [31:0] ref_addr(input logic [31:0] a);
`ifdef LINE_BURST_WRAP_EN
    return a - (a % 8);
`else
    return a - (a % 32);
`endif
  endfunction

  function automatic int ref_slot(input logic [31:0] a, input int k);
`ifdef LINE_BURST_WRAP_EN
    return (int'((a / 8) % 4) + k) % 4;
`else
    return k;
`endif
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Drives one line request and plays the memory side; reports what was observed.
  task automatic run_line(input bit rd, input bit both, input logic [31:0] addr,
                          input logic [255:0] wl, input logic [3:0][63:0] rbeats,
                          input logic [3:0][3:0] gaps,
                          output int lat, output logic [31:0] oaddr,
                          output logic [3:0][63:0] wbeats, output logic [255:0] rline,
                          output int drops, output int other, output bit resp_after,
                          output bit tmo);
    int  k, gl, cyc;
    bit  done;
    k = 0; gl = int'(gaps[0]); lat = 0; oaddr = '0; wbeats = '0; rline = '0;
    drops = 0; other = 0; resp_after = 1'b0; tmo = 1'b0; done = 1'b0;
    @(negedge clk);
    bif.line_address_i = addr;
    bif.line_wdata_i   = wl;
    bif.line_read_i    = rd;
    bif.line_write_i   = !rd || both;
    for (cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      if (bif.line_resp_o) begin
        lat = cyc; rline = bif.line_rdata_o; done = 1'b1;
        bif.line_read_i = 1'b0; bif.line_write_i = 1'b0; bif.burst_resp_i = 1'b0;
      end else begin
        if (cyc == 1) oaddr = bif.burst_address_o;
        if (rd ? !bif.burst_read_o : !bif.burst_write_o) drops++;
        if (rd ? bif.burst_write_o : bif.burst_read_o) other++;
        if (k < 4 && gl == 0) begin
          bif.burst_resp_i  = 1'b1;
          bif.burst_rdata_i = rbeats[k];
          wbeats[k]         = bif.burst_wdata_o;
          k++;
          if (k < 4) gl = int'(gaps[k]);
        end else begin
          bif.burst_resp_i  = 1'b0;
          bif.burst_rdata_i = rand64();
          if (gl > 0) gl--;
        end
      end
    end
    if (!done) begin
      tmo = 1'b1;
      bif.line_read_i = 1'b0; bif.line_write_i = 1'b0; bif.burst_resp_i = 1'b0;
    end else begin
      @(negedge clk);
      resp_after = bif.line_resp_o;
    end
    $display("txn %s addr=%h burst_addr=%h lat=%0d", rd ? "read " : "write", addr, oaddr, lat);
  endtask

  task automatic test_reset();
    bif.line_address_i = '0; bif.line_wdata_i = '0; bif.line_read_i = 1'b0;
    bif.line_write_i = 1'b0; bif.burst_rdata_i = '0; bif.burst_resp_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bif.line_resp_o, bif.burst_read_o, bif.burst_write_o} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes: got %b want 000",
                      {bif.line_resp_o, bif.burst_read_o, bif.burst_write_o});
    end
    total++;
    if ({bif.burst_address_o, bif.burst_wdata_o, bif.line_rdata_o} !== '0) begin
      bad++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0",
                      bif.burst_address_o, bif.burst_wdata_o, bif.line_rdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_back_to_back();
    logic [3:0][63:0] rb, wb;
    logic [255:0] rl, exp;
    logic [31:0] oa;
    int lat, drops, other; bit ra, tmo;
    rb = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_line(1'b1, 1'b0, 32'h0000_1234, '0, rb, '0, lat, oa, wb, rl, drops, other, ra, tmo);
    exp = '0;
    for (int k = 0; k < 4; k++) exp[ref_slot(32'h0000_1234, k)*64 +: 64] = rb[k];
    total++; if (tmo) begin bad++; $display("FAIL rd_timeout: got no line_resp_o want pulse"); end
    total++; if (lat !== 5) begin bad++; $display("FAIL rd_latency: got %0d want 5", lat); end
    total++; if (oa !== ref_addr(32'h0000_1234)) begin
      bad++; $display("FAIL rd_addr: got %h want %h", oa, ref_addr(32'h0000_1234)); end
    total++; if (rl !== exp) begin bad++; $display("FAIL rd_data: got %h want %h", rl, exp); end
    total++; if (drops !== 0 || other !== 0) begin
      bad++; $display("FAIL rd_strobes: drops=%0d other=%0d want 0 0", drops, other); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL rd_resp_pulse: got %b want 0 after DONE", ra); end
  endtask

  task automatic test_write_gap();
    logic [3:0][63:0] rb, wb;
    logic [3:0][3:0] gaps;
    logic [255:0] rl, wl;
    logic [31:0] oa, a;
    int lat, drops, other; bit ra, tmo;
    a  = 32'h0000_2040;
    wl = {64'hDEAD_3333_3333_3333, 64'hDEAD_2222_2222_2222,
          64'hDEAD_1111_1111_1111, 64'hDEAD_0000_0000_BEEF};
    rb = '0; gaps = '0; gaps[1] = 4'd2;
    run_line(1'b0, 1'b0, a, wl, rb, gaps, lat, oa, wb, rl, drops, other, ra, tmo);
    total++; if (lat !== 7 || tmo) begin bad++; $display("FAIL wr_latency: got %0d want 7", lat); end
    total++; if (oa !== ref_addr(a)) begin bad++; $display("FAIL wr_addr: got %h want %h", oa, ref_addr(a)); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wb[k] !== wl[ref_slot(a, k)*64 +: 64]) begin
        bad++; $display("FAIL wr_beat%0d: got %h want %h", k, wb[k], wl[ref_slot(a, k)*64 +: 64]);
      end
    end
    total++; if (drops !== 0 || other !== 0) begin
      bad++; $display("FAIL wr_strobe_held: drops=%0d other=%0d want 0 0", drops, other); end
  endtask

  task automatic test_simultaneous();
    logic [3:0][63:0] rb, wb;
    logic [255:0] rl, exp;
    logic [31:0] oa, a;
    int lat, drops, other; bit ra, tmo;
    a = $urandom;
    for (int k = 0; k < 4; k++) rb[k] = rand64();
    run_line(1'b1, 1'b1, a, {8{$urandom}}, rb, '0, lat, oa, wb, rl, drops, other, ra, tmo);
    exp = '0;
    for (int k = 0; k < 4; k++) exp[ref_slot(a, k)*64 +: 64] = rb[k];
    total++; if (other !== 0) begin bad++; $display("FAIL both_write_strobe: got %0d cycles want 0", other); end
    total++; if (drops !== 0 || lat !== 5) begin
      bad++; $display("FAIL both_read: drops=%0d lat=%0d want 0 5", drops, lat); end
    total++; if (rl !== exp) begin bad++; $display("FAIL both_data: got %h want %h", rl, exp); end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0][63:0] rb, wb;
    logic [255:0] rl, exp;
    logic [31:0] oa, a;
    int lat, drops, other; bit ra, tmo;
    @(negedge clk);
    bif.line_address_i = 32'h0000_3000; bif.line_read_i = 1'b1;
    @(negedge clk); bif.burst_resp_i = 1'b1; bif.burst_rdata_i = 64'hAAAA_0000_0000_0001;
    @(negedge clk); bif.burst_rdata_i = 64'hAAAA_0000_0000_0002;
    @(negedge clk); bif.burst_resp_i = 1'b0; bif.line_read_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bif.line_resp_o, bif.burst_read_o, bif.burst_write_o} !== 3'b000 ||
        bif.burst_address_o !== '0 || bif.burst_wdata_o !== '0 || bif.line_rdata_o !== '0) begin
      bad++; $display("FAIL midrst_outputs: resp=%b rd=%b wr=%b addr=%h rdata=%h want all 0",
                      bif.line_resp_o, bif.burst_read_o, bif.burst_write_o,
                      bif.burst_address_o, bif.line_rdata_o);
    end
    rst = 1'b0;
    a = 32'h0000_3018;
    for (int k = 0; k < 4; k++) rb[k] = rand64();
    run_line(1'b1, 1'b0, a, '0, rb, '0, lat, oa, wb, rl, drops, other, ra, tmo);
    exp = '0;
    for (int k = 0; k < 4; k++) exp[ref_slot(a, k)*64 +: 64] = rb[k];
    total++; if (lat !== 5 || rl !== exp) begin
      bad++; $display("FAIL midrst_reread: lat=%0d data=%h want 5 %h", lat, rl, exp); end
  endtask

  task automatic test_spurious_resp();
    logic [3:0][63:0] rb, wb;
    logic [255:0] rl, exp;
    logic [31:0] oa, a;
    int lat, drops, other; bit ra, tmo;
    @(negedge clk);
    bif.burst_resp_i = 1'b1; bif.burst_rdata_i = rand64();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bif.line_resp_o, bif.burst_read_o, bif.burst_write_o} !== 3'b000) begin
        bad++; $display("FAIL spurious_idle%0d: got %b want 000", i,
                        {bif.line_resp_o, bif.burst_read_o, bif.burst_write_o});
      end
    end
    bif.burst_resp_i = 1'b0;
    a = $urandom;
    for (int k = 0; k < 4; k++) rb[k] = rand64();
    run_line(1'b1, 1'b0, a, '0, rb, '0, lat, oa, wb, rl, drops, other, ra, tmo);
    exp = '0;
    for (int k = 0; k < 4; k++) exp[ref_slot(a, k)*64 +: 64] = rb[k];
    total++; if (lat !== 5 || rl !== exp) begin
      bad++; $display("FAIL spurious_after: lat=%0d data=%h want 5 %h", lat, rl, exp); end
  endtask

  task automatic test_random();
    logic [3:0][63:0] rb, wb;
    logic [3:0][3:0] gaps;
    logic [255:0] rl, wl, exp;
    logic [31:0] oa, a;
    int lat, drops, other, want_lat; bit ra, tmo, rd;
    for (int t = 0; t < 10; t++) begin
      rd = 1'($urandom_range(0, 1));
      a  = $urandom;
      wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      want_lat = 5;
      for (int k = 0; k < 4; k++) begin
        rb[k] = rand64();
        gaps[k] = 4'($urandom_range(0, 2));
        want_lat += int'(gaps[k]);
      end
      run_line(rd, 1'b0, a, wl, rb, gaps, lat, oa, wb, rl, drops, other, ra, tmo);
      total++; if (lat !== want_lat || tmo) begin
        bad++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, want_lat); end
      total++; if (oa !== ref_addr(a)) begin
        bad++; $display("FAIL rand%0d_addr: got %h want %h", t, oa, ref_addr(a)); end
      total++; if (drops !== 0 || other !== 0 || ra !== 1'b0) begin
        bad++; $display("FAIL rand%0d_strobes: drops=%0d other=%0d resp_after=%b want 0 0 0",
                        t, drops, other, ra); end
      exp = '0;
      for (int k = 0; k < 4; k++) begin
        if (rd) exp[ref_slot(a, k)*64 +: 64] = rb[k];
        else    exp[k*64 +: 64] = wl[ref_slot(a, k)*64 +: 64];
      end
      total++; if ((rd ? rl : 256'(wb)) !== exp) begin
        bad++; $display("FAIL rand%0d_data: got %h want %h", t, rd ? rl : 256'(wb), exp); end
    end
  endtask

`ifdef LINE_BURST_WRAP_EN
  task automatic test_wrap();
    logic [3:0][63:0] rb, wb;
    logic [255:0] rl, exp;
    logic [31:0] oa;
    int lat, drops, other; bit ra, tmo;
    rb = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    exp = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA,
           64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC};
    run_line(1'b1, 1'b0, 32'h0000_1230, '0, rb, '0, lat, oa, wb, rl, drops, other, ra, tmo);
    total++; if (oa !== 32'h0000_1230) begin bad++; $display("FAIL wrap_addr: got %h want 00001230", oa); end
    total++; if (rl !== exp) begin bad++; $display("FAIL wrap_data: got %h want %h", rl, exp); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_read_back_to_back();
    test_write_gap();
    test_simultaneous();
    test_reset_mid_burst();
    test_spurious_resp();
    test_random();
`ifdef LINE_BURST_WRAP_EN
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
